// File: rtl/noc_input_buffer.sv
// Router input buffer: two per-VC show-ahead FIFOs with credit return, lock tracking and
// packet-atomic round-robin arbitration. Define NOC_IBUF_STATS_EN to add per-VC dequeue counters.
module noc_input_buffer #(
  parameter int DATAW = 64,
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [DATAW-1:0] idata,
  input  logic             ivalid,
  input  logic             ivch,
  output logic [1:0]       oack,
  output logic [1:0]       olck,
  output logic [DATAW-1:0] odata,
  output logic             ovalid,
  output logic             ovch,
  input  logic             igrant,
`ifdef NOC_IBUF_STATS_EN
  output logic [15:0]      ocnt0,
  output logic [15:0]      ocnt1,
`endif
  output logic             oerr
);

  localparam logic [1:0] T_HEAD = 2'b00;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_HT   = 2'b11;
  localparam logic [PTRW:0] FULL_CNT = (PTRW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD0 = 2'd1, HOLD1 = 2'd2} state_t;

  logic [DATAW-1:0] mem_q [2][DEPTH];
  logic [PTRW-1:0]  wr_ptr_q [2];
  logic [PTRW-1:0]  rd_ptr_q [2];
  logic [PTRW:0]    cnt_q [2];
  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic [1:0]       oack_q, olck_q, olck_d;
  logic             oerr_q;

  logic [1:0]       nonempty, wr_en, deq_v;
  logic             sel, ovalid_c, deq, ovf;
  logic [DATAW-1:0] head;
  logic [1:0]       out_type, in_type;

  assign in_type = idata[DATAW-1 -: 2];

  always_comb begin
    for (int v = 0; v < 2; v++) nonempty[v] = (cnt_q[v] != '0);
    sel      = 1'b0;
    ovalid_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (nonempty[prio_q]) begin
          sel      = prio_q;
          ovalid_c = 1'b1;
        end else if (nonempty[~prio_q]) begin
          sel      = ~prio_q;
          ovalid_c = 1'b1;
        end
      end
      HOLD0: begin
        sel      = 1'b0;
        ovalid_c = nonempty[0];
      end
      HOLD1: begin
        sel      = 1'b1;
        ovalid_c = nonempty[1];
      end
      default: ;
    endcase
    head     = mem_q[sel][rd_ptr_q[sel]];
    out_type = head[DATAW-1 -: 2];
    deq      = ovalid_c & igrant;
    deq_v    = {deq & sel, deq & ~sel};
  end

  // Packet atomicity: a head locks the arbiter onto its VC until the tail leaves.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    if (deq) begin
      case (state_q)
        IDLE: begin
          if (out_type == T_HEAD) state_d = sel ? HOLD1 : HOLD0;
          if (out_type == T_HEAD || out_type == T_HT) prio_d = ~sel;
        end
        HOLD0, HOLD1: if (out_type == T_TAIL) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // A full FIFO still accepts a flit when the same edge frees a slot.
  always_comb begin
    ovf = 1'b0;
    for (int v = 0; v < 2; v++) begin
      wr_en[v]  = ivalid & (ivch == 1'(v)) & ((cnt_q[v] != FULL_CNT) | deq_v[v]);
      ovf       = ovf | (ivalid & (ivch == 1'(v)) & (cnt_q[v] == FULL_CNT) & ~deq_v[v]);
      olck_d[v] = olck_q[v];
      if (deq_v[v] && (out_type == T_TAIL || out_type == T_HT)) olck_d[v] = 1'b0;
      if (wr_en[v] && (in_type == T_HEAD || in_type == T_HT))   olck_d[v] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < 2; v++)
      if (wr_en[v]) mem_q[v][wr_ptr_q[v]] <= idata;
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      for (int v = 0; v < 2; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        cnt_q[v]    <= '0;
      end
      state_q <= IDLE;
      prio_q  <= 1'b0;
      oack_q  <= '0;
      olck_q  <= '0;
      oerr_q  <= 1'b0;
    end else begin
      for (int v = 0; v < 2; v++) begin
        if (wr_en[v]) wr_ptr_q[v] <= wr_ptr_q[v] + PTRW'(1);
        if (deq_v[v]) rd_ptr_q[v] <= rd_ptr_q[v] + PTRW'(1);
        cnt_q[v] <= cnt_q[v] + (PTRW+1)'(wr_en[v]) - (PTRW+1)'(deq_v[v]);
      end
      state_q <= state_d;
      prio_q  <= prio_d;
      oack_q  <= deq_v;
      olck_q  <= olck_d;
      oerr_q  <= oerr_q | ovf;
    end
  end

`ifdef NOC_IBUF_STATS_EN
  logic [15:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk) begin
    if (rst_) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (deq_v[0]) cnt0_q <= cnt0_q + 16'd1;
      if (deq_v[1]) cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign ocnt0 = cnt0_q;
  assign ocnt1 = cnt1_q;
`endif

  assign odata  = ovalid_c ? head : '0;
  assign ovalid = ovalid_c;
  assign ovch   = ovalid_c ? sel : 1'b0;
  assign oack   = oack_q;
  assign olck   = olck_q;
  assign oerr   = oerr_q;

endmodule

// File: tb/tb_noc_input_buffer.sv
// Directed bench for noc_input_buffer: expected flits are queued as they are sent and
// compared in order when the switch accepts them.
module tb_noc_input_buffer;

  localparam int DATAW = 64;

  logic             clk = 1'b0;
  logic             rst_ = 1'b1;
  logic [DATAW-1:0] idata = '0;
  logic             ivalid = 1'b0;
  logic             ivch = 1'b0;
  logic             igrant = 1'b0;
  logic [1:0]       oack, olck;
  logic [DATAW-1:0] odata;
  logic             ovalid, ovch, oerr;
`ifdef NOC_IBUF_STATS_EN
  logic [15:0]      ocnt0, ocnt1;
`endif

  noc_input_buffer #(.DATAW(DATAW), .DEPTH(4), .PTRW(2)) dut (
    .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch),
    .oack(oack), .olck(olck), .odata(odata), .ovalid(ovalid), .ovch(ovch),
    .igrant(igrant),
`ifdef NOC_IBUF_STATS_EN
    .ocnt0(ocnt0), .ocnt1(ocnt1),
`endif
    .oerr(oerr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             vc;
    logic [DATAW-1:0] d;
  } exp_t;

  exp_t       sbq[$];
  int         checks = 0;
  int         errors = 0;
  logic [1:0] exp_ack = 2'b00;

  function automatic logic [DATAW-1:0] flit(input logic [1:0] t, input logic [7:0] tag);
    flit = {t, 54'h0, tag};
  endfunction

  task automatic chk(input string tag, input logic [DATAW-1:0] obs, input logic [DATAW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic vc, input logic [DATAW-1:0] d);
    exp_t e;
    e.vc = vc;
    e.d  = d;
    sbq.push_back(e);
  endtask

  // One clock cycle: drive inputs after the edge, check outputs on the falling edge.
  task automatic cyc(input logic v, input logic vc, input logic [DATAW-1:0] d, input logic g);
    exp_t e;
    @(posedge clk); #1;
    ivalid = v; ivch = vc; idata = d; igrant = g;
    @(negedge clk);
    chk("oack", DATAW'(oack), DATAW'(exp_ack));
    if (ovalid && igrant) begin
      if (sbq.size() == 0) begin
        chk("unexpected_flit", DATAW'(1), DATAW'(0));
        exp_ack = 2'b00;
      end else begin
        e = sbq.pop_front();
        chk("ovch", DATAW'(ovch), DATAW'(e.vc));
        chk("odata", odata, e.d);
        exp_ack = e.vc ? 2'b10 : 2'b01;
      end
    end else begin
      exp_ack = 2'b00;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_ = 1'b1; ivalid = 1'b0; igrant = 1'b0;
    @(posedge clk); #1;
    rst_ = 1'b0;
    @(negedge clk);
    sbq.delete();
    exp_ack = 2'b00;
    chk("rst_ovalid", DATAW'(ovalid), '0);
    chk("rst_odata", odata, '0);
    chk("rst_ovch", DATAW'(ovch), '0);
    chk("rst_oack", DATAW'(oack), '0);
    chk("rst_olck", DATAW'(olck), '0);
    chk("rst_oerr", DATAW'(oerr), '0);
  endtask

  initial begin
    do_reset();

    // single head-tail on VC0
    push(0, flit(2'b11, 8'h11));
    cyc(1, 0, flit(2'b11, 8'h11), 1);
    chk("t1_no_bypass", DATAW'(ovalid), '0);
    cyc(0, 0, '0, 1);
    chk("t1_olck", DATAW'(olck), DATAW'(2'b01));
    cyc(0, 0, '0, 0);
    chk("t1_olck_clr", DATAW'(olck), '0);
    chk("t1_empty", DATAW'(ovalid), '0);

    // 3-flit packet on VC1, held then drained
    push(1, flit(2'b00, 8'h21));
    push(1, flit(2'b01, 8'h22));
    push(1, flit(2'b10, 8'h23));
    cyc(1, 1, flit(2'b00, 8'h21), 0);
    cyc(1, 1, flit(2'b01, 8'h22), 0);
    chk("t2_olck_set", DATAW'(olck), DATAW'(2'b10));
    cyc(1, 1, flit(2'b10, 8'h23), 0);
    cyc(0, 0, '0, 0);
    chk("t2_ovalid", DATAW'(ovalid), DATAW'(1));
    chk("t2_ovch", DATAW'(ovch), DATAW'(1));
    chk("t2_head", odata, flit(2'b00, 8'h21));
    repeat (3) cyc(0, 0, '0, 1);
    cyc(0, 0, '0, 0);
    chk("t2_olck_clr", DATAW'(olck), '0);
    chk("t2_empty", DATAW'(ovalid), '0);

    // interleaved packets must leave packet-atomically
    push(0, flit(2'b00, 8'h31));
    push(0, flit(2'b01, 8'h32));
    push(0, flit(2'b10, 8'h33));
    push(1, flit(2'b00, 8'h41));
    push(1, flit(2'b01, 8'h42));
    push(1, flit(2'b10, 8'h43));
    cyc(1, 0, flit(2'b00, 8'h31), 1);
    cyc(1, 1, flit(2'b00, 8'h41), 1);
    cyc(1, 0, flit(2'b01, 8'h32), 1);
    chk("t3_hold_vc0", DATAW'(ovalid), '0);
    cyc(1, 1, flit(2'b01, 8'h42), 1);
    cyc(1, 0, flit(2'b10, 8'h33), 1);
    chk("t3_hold_vc0b", DATAW'(ovalid), '0);
    cyc(1, 1, flit(2'b10, 8'h43), 1);
    repeat (4) cyc(0, 0, '0, 1);
    chk("t3_drained", DATAW'(sbq.size()), '0);
    chk("t3_empty", DATAW'(ovalid), '0);

    // overflow: fifth flit into a full VC0 is dropped
    push(0, flit(2'b00, 8'h51));
    push(0, flit(2'b01, 8'h52));
    push(0, flit(2'b01, 8'h53));
    push(0, flit(2'b01, 8'h54));
    cyc(1, 0, flit(2'b00, 8'h51), 0);
    cyc(1, 0, flit(2'b01, 8'h52), 0);
    cyc(1, 0, flit(2'b01, 8'h53), 0);
    cyc(1, 0, flit(2'b01, 8'h54), 0);
    cyc(1, 0, flit(2'b10, 8'h55), 0);
    chk("t4_oerr_pre", DATAW'(oerr), '0);
    cyc(0, 0, '0, 0);
    chk("t4_oerr", DATAW'(oerr), DATAW'(1));
    repeat (4) cyc(0, 0, '0, 1);
    cyc(0, 0, '0, 1);
    chk("t4_dropped", DATAW'(ovalid), '0);
    chk("t4_oerr_sticky", DATAW'(oerr), DATAW'(1));

    do_reset();

    // full VC0 with simultaneous enqueue and dequeue, across pointer wrap
    push(0, flit(2'b00, 8'h61));
    push(0, flit(2'b01, 8'h62));
    push(0, flit(2'b01, 8'h63));
    push(0, flit(2'b01, 8'h64));
    push(0, flit(2'b01, 8'h65));
    push(0, flit(2'b10, 8'h66));
    cyc(1, 0, flit(2'b00, 8'h61), 0);
    cyc(1, 0, flit(2'b01, 8'h62), 0);
    cyc(1, 0, flit(2'b01, 8'h63), 0);
    cyc(1, 0, flit(2'b01, 8'h64), 0);
    cyc(1, 0, flit(2'b01, 8'h65), 1);
    cyc(1, 0, flit(2'b10, 8'h66), 1);
    repeat (4) cyc(0, 0, '0, 1);
    cyc(0, 0, '0, 0);
    chk("t5_drained", DATAW'(sbq.size()), '0);
    chk("t5_empty", DATAW'(ovalid), '0);
    chk("t5_oerr", DATAW'(oerr), '0);
    chk("t5_olck", DATAW'(olck), '0);

    // reset while VC1 holds two flits of a locked packet
    push(1, flit(2'b00, 8'h71));
    cyc(1, 1, flit(2'b00, 8'h71), 1);
    cyc(1, 1, flit(2'b01, 8'h72), 1);
    cyc(1, 1, flit(2'b01, 8'h73), 0);
    cyc(0, 0, '0, 0);
    chk("t6_pre_olck", DATAW'(olck), DATAW'(2'b10));
    chk("t6_pre_ovch", DATAW'(ovch), DATAW'(1));
    do_reset();
    push(0, flit(2'b00, 8'h81));
    push(0, flit(2'b10, 8'h82));
    cyc(1, 0, flit(2'b00, 8'h81), 1);
    cyc(1, 0, flit(2'b10, 8'h82), 1);
    chk("t6_olck_new", DATAW'(olck), DATAW'(2'b01));
    cyc(0, 0, '0, 1);
    cyc(0, 0, '0, 0);
    chk("t6_olck_clr", DATAW'(olck), '0);
    chk("t6_drained", DATAW'(sbq.size()), '0);
    chk("t6_empty", DATAW'(ovalid), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
